// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the single memory port served by mem_arbiter.
// The slave side is the arbiter; the master side is everything around it (F, D and memory).
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic              f_err;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_err, f_rdata, d_ack, d_err, d_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between fetch (F) and load/store (D).
// Each access takes IDLE -> ACCESS -> RESP; all outputs come straight from registers.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_BYTES = 64
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic              PORT_F   = 1'b0;
    localparam logic              PORT_D   = 1'b1;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 2);

    state_t            state_reg;
    logic              last_grant_reg;
    logic              owner_reg;
    logic              we_reg;
    logic              err_reg;
    logic [1:0]        ack_reg;
    logic [1:0]        perr_reg;
    logic [DATA_W-1:0] rdata_reg [2];
    logic [DATA_W-1:0] rdata_out [2];
    logic              mem_en_reg;
    logic              mem_rw_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic              grant_d_next;
    logic [ADDR_W-1:0] sel_addr_next;
    logic [DATA_W-1:0] sel_wdata_next;
    logic              sel_we_next;
    logic              sel_err_next;

    // D wins unless F is also asking and D was the last one served.
    always_comb begin
        grant_d_next   = bus.d_req && (!bus.f_req || (last_grant_reg == PORT_F));
        sel_addr_next  = grant_d_next ? bus.d_addr : bus.f_addr;
        sel_wdata_next = grant_d_next ? bus.d_wdata : '0;
        sel_we_next    = grant_d_next && bus.d_we;
        sel_err_next   = (sel_addr_next > MAX_ADDR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= PORT_F;
            owner_reg      <= PORT_F;
            we_reg         <= 1'b0;
            err_reg        <= 1'b0;
            ack_reg        <= '0;
            perr_reg       <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
            mem_en_reg     <= 1'b0;
            mem_rw_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            ack_reg       <= '0;
            perr_reg      <= '0;
            mem_en_reg    <= 1'b0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (bus.f_req || bus.d_req) begin
                        owner_reg      <= grant_d_next;
                        last_grant_reg <= grant_d_next;
                        we_reg         <= sel_we_next;
                        err_reg        <= sel_err_next;
                        // The memory strobe is set up here so it is live for exactly the ACCESS cycle.
                        if (!sel_err_next) begin
                            mem_en_reg    <= 1'b1;
                            mem_rw_reg    <= sel_we_next;
                            mem_addr_reg  <= sel_addr_next;
                            mem_wdata_reg <= sel_wdata_next;
                        end
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    ack_reg[owner_reg]  <= 1'b1;
                    perr_reg[owner_reg] <= err_reg;
                    state_reg           <= RESP;
                end
                RESP: begin
                    if (!we_reg) begin
                        rdata_reg[owner_reg] <= err_reg ? '0 : bus.mem_rdata;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // During RESP the fresh read word bypasses the holding register so it lines up with ack.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            assign rdata_out[gi] = ((state_reg == RESP) && (owner_reg == 1'(gi)) && !we_reg)
                                   ? (err_reg ? '0 : bus.mem_rdata)
                                   : rdata_reg[gi];
        end
    endgenerate

    assign bus.f_ack     = ack_reg[PORT_F];
    assign bus.d_ack     = ack_reg[PORT_D];
    assign bus.f_err     = perr_reg[PORT_F];
    assign bus.d_err     = perr_reg[PORT_D];
    assign bus.f_rdata   = rdata_out[0];
    assign bus.d_rdata   = rdata_out[1];
    assign bus.mem_en    = mem_en_reg;
    assign bus.mem_rw    = mem_rw_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the 64-byte byte-addressed data memory. It shares the single memory port between the instruction-fetch unit (port F) and the load/store unit (port D). It serialises their 16-bit word accesses into one-cycle memory operations and returns read data with a single-cycle acknowledge. The block sits between the CPU front end and the memory, and owns all memory control signals: the memory has no other driver.

## Interface
- ADDR_W, 16, width of all address buses
- DATA_W, 16, word width (fixed at 16: memory stores big-endian byte pairs)
- MEM_BYTES, 64, memory size in bytes; legal word address range 0..MEM_BYTES-2

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request (read only)
- f_addr  in  ADDR_W  fetch byte address
- f_ack  out  1  one-cycle response pulse to F
- f_err  out  1  valid with f_ack; address out of range
- f_rdata  out  DATA_W  fetch read data, valid with f_ack, held until next F response
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle response pulse to D
- d_err  out  1  valid with d_ack; address out of range
- d_rdata  out  DATA_W  data read result, valid with d_ack, held until next D response
- mem_en  out  1  memory access strobe, exactly one cycle per legal access
- mem_rw  out  1  1 = write, 0 = read (same encoding as the memory's MemRW)
- mem_addr  out  ADDR_W  byte address; word occupies mem_addr and mem_addr+1
- mem_wdata  out  DATA_W  write data, [15:8] to mem_addr, [7:0] to mem_addr+1
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: a request is accepted if any req is high. The arbiter latches owner, we (forced 0 for F), addr and wdata into internal registers, then goes to ACCESS. It stays in IDLE if there is no request.
- Arbitration is round-robin on the last_grant bit.
  - One requester high: it is granted.
  - Both high: the port not granted last wins.
  - last_grant resets to F, so D wins the first tie.
  - last_grant updates on every grant.
- Range check happens at latch time: err_q = (addr > MEM_BYTES-2).
- ACCESS:
  - If !err_q, mem_en=1, mem_rw=we_q, mem_addr=addr_q, mem_wdata=wdata_q.
  - If err_q, mem_en=0. No write ever reaches memory for an illegal address.
  - The FSM always goes to RESP.
- RESP:
  - The owner's ack is 1 and its err equals err_q.
  - For a legal read, the owner's rdata register is loaded from mem_rdata on the edge leaving RESP. The value is also driven through combinationally during RESP so it is valid with ack.
  - For a read with err, rdata is loaded with 0x0000.
  - For a write, rdata is unchanged.
  - The FSM then goes to IDLE.
- Requests are sampled only in IDLE. req changes during ACCESS/RESP are ignored.
- Requester protocol: hold req, addr, we and wdata stable until ack. A req still high in the IDLE cycle after ack is a new request.
- The non-owner's ack and err are 0 at all times.
- mem_* outputs are 0 in every state other than ACCESS.

## Timing
- Reset values (next edge with rst=1):
  - state=IDLE, last_grant=F
  - f_ack=d_ack=f_err=d_err=0
  - f_rdata=d_rdata=0x0000
  - mem_en=mem_rw=0, mem_addr=mem_wdata=0
- Latency: req high at IDLE edge N → ACCESS in cycle N+1 → ack in cycle N+2.
- Throughput: one access per 3 cycles.
- A request asserted continuously gets back-to-back service every 3 cycles.
- When both ports are asserted continuously, grants alternate D,F,D,F…
- Reset mid-operation:
  - A write whose ACCESS cycle coincides with the rst edge is committed by the memory.
  - No ack is issued for any in-flight access.
  - Outputs take reset values on that edge.
- Boundary addresses:
  - MEM_BYTES-2 (62) is legal.
  - 63 and above are errors, including addresses above 0xFF (full 16-bit compare).

## Test plan
- Reset: hold rst 2 cycles with f_req=d_req=1 → no ack, mem_en=0, both rdata=0x0000; after release, D is granted first.
- D write then F read: D writes 0xA55A to 0x0010; F then reads 0x0010 → d_ack 2 cycles after grant; mem_en for one cycle with mem_rw=1; f_rdata=0xA55A with f_ack, f_err=0.
- Contention: f_req and d_req held high for 12 cycles → grants D,F,D,F; each ack is a one-cycle pulse, 3 cycles apart.
- Boundary: D reads 0x003E → legal, mem_en=1. D writes 0x003F → d_err=1, mem_en never asserted, memory byte 63 unchanged. F reads 0x0100 → f_err=1, f_rdata=0x0000.
- Hold semantics: F read returns 0x1234; a later D read returns 0x5678 → f_rdata stays 0x1234 throughout.
- Mid-op reset: assert rst during the RESP cycle of an F read → f_ack forced 0 on that edge, f_rdata=0x0000, FSM IDLE.
